// File: rtl/sound_tick_pkg.sv
// -----------------------------------------------------------------------------
// sound_tick_pkg
// Shared definitions for the sound tick controller:
//   - state_e : FSM state encoding (IDLE, RUN, DONE)
//   - N_DEF   : default width of the divisor and of the tick counter
//   - K_W_DEF : default width of the one-shot tick count and tally
// -----------------------------------------------------------------------------
package sound_tick_pkg;

  localparam int N_DEF   = 16;
  localparam int K_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : sound_tick_pkg

// File: rtl/tick_div_counter.sv
// -----------------------------------------------------------------------------
// tick_div_counter
// N-bit programmable modulo counter. While enabled it counts 0 .. period-1
// and then wraps to 0; wrap is high in the cycle the count equals period-1.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, clears the count
//   clr    : synchronous clear of the count (priority over en)
//   en     : count enable
//   period : modulo value, expected >= 1 (caller clamps 0 to 1)
//   wrap   : high while enabled and the count equals period-1
// -----------------------------------------------------------------------------
module tick_div_counter #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [N-1:0] period,
  output logic         wrap
);

  localparam logic [N-1:0] ONE_N = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;
  logic [N-1:0] last_w;

  // Terminal value computed at N bits so the compare never widens.
  assign last_w = period - ONE_N;
  assign wrap   = en && (count_q == last_w);

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = wrap ? '0 : (count_q + ONE_N);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : tick_div_counter

// File: rtl/sound_tick_ctrl.sv
// -----------------------------------------------------------------------------
// sound_tick_ctrl
// Tick generator for sound sequencing. Emits a one-cycle tick every D clk
// cycles while running, either indefinitely (periodic) or for C ticks
// (one-shot) followed by a one-cycle done pulse.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | stopped; configuration writes accepted, start launches a run
//   RUN   | counting; ticks emitted, configuration writes rejected
//   DONE  | one-shot finished, done high for this single cycle
//
// Ports:
//   clk         : clock, rising edge
//   rst         : asynchronous active-high reset
//   cfg_we      : configuration write strobe
//   cfg_div     : tick period in clk cycles (0 behaves as 1)
//   cfg_cnt     : ticks per one-shot run (0 behaves as 1)
//   cfg_oneshot : 1 = one-shot, 0 = periodic
//   start       : run request (ignored while running)
//   stop        : abort request (wins over start)
//   tick        : one-cycle period pulse
//   busy        : high while in RUN
//   done        : one-cycle pulse at one-shot completion
//   cfg_err     : one-cycle pulse after a configuration write during RUN
//   irq_ack     : interrupt acknowledge (only with SOUND_TICK_IRQ_EN)
//   irq         : sticky interrupt on done/cfg_err (only with SOUND_TICK_IRQ_EN)
//
// Build option: define SOUND_TICK_IRQ_EN to add the irq/irq_ack interface.
// -----------------------------------------------------------------------------
module sound_tick_ctrl
  import sound_tick_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int K_W = K_W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_we,
  input  logic [N-1:0]   cfg_div,
  input  logic [K_W-1:0] cfg_cnt,
  input  logic           cfg_oneshot,
  input  logic           start,
  input  logic           stop,
`ifdef SOUND_TICK_IRQ_EN
  input  logic           irq_ack,
  output logic           irq,
`endif
  output logic           tick,
  output logic           busy,
  output logic           done,
  output logic           cfg_err
);

  localparam logic [N-1:0]   ONE_N = {{(N-1){1'b0}}, 1'b1};
  localparam logic [K_W-1:0] ONE_K = {{(K_W-1){1'b0}}, 1'b1};

  state_e         state_q;
  logic [N-1:0]   div_q;
  logic [K_W-1:0] cnt_q;
  logic           mode_q;
  logic [K_W-1:0] tally_q;
  logic           cfg_err_q;

  logic [N-1:0]   period_w;
  logic [K_W-1:0] last_tally_w;
  logic           running_w;
  logic           start_go_w;
  logic           wrap_w;

  // Zero settings are clamped to 1 so a blank configuration still runs.
  assign period_w     = (div_q == '0) ? ONE_N : div_q;
  assign last_tally_w = ((cnt_q == '0) ? ONE_K : cnt_q) - ONE_K;

  assign running_w  = (state_q == RUN);
  // A simultaneous stop suppresses the start; in DONE the run ends anyway.
  assign start_go_w = !running_w && start && !stop;

  tick_div_counter #(
    .N (N)
  ) u_div (
    .clk    (clk),
    .rst    (rst),
    .clr    (start_go_w),
    .en     (running_w),
    .period (period_w),
    .wrap   (wrap_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      cnt_q     <= '0;
      mode_q    <= 1'b0;
      tally_q   <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (cfg_we) begin
            div_q  <= cfg_div;
            cnt_q  <= cfg_cnt;
            mode_q <= cfg_oneshot;
          end
          if (start_go_w) begin
            state_q <= RUN;
            tally_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (cfg_we) begin
            cfg_err_q <= 1'b1;
          end
          if (stop) begin
            state_q <= IDLE;
          end else if (wrap_w && mode_q) begin
            tally_q <= tally_q + ONE_K;
            if (tally_q == last_tally_w) begin
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // tick depends only on registered state, so it is glitch-safe and drops
  // with the asynchronous reset.
  assign tick    = wrap_w;
  assign busy    = running_w;
  assign done    = (state_q == DONE);
  assign cfg_err = cfg_err_q;

`ifdef SOUND_TICK_IRQ_EN
  logic irq_q;

  // Set has priority so an event coinciding with an acknowledge is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_q <= 1'b0;
    end else if (done || cfg_err_q) begin
      irq_q <= 1'b1;
    end else if (irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign irq = irq_q;
`endif

  a_tick_in_run : assert property (@(posedge clk) disable iff (rst) tick |-> busy);
  a_done_single : assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule : sound_tick_ctrl

// File: tb/tb_sound_tick_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sound_tick_ctrl
// Directed bench for sound_tick_ctrl. Cycle numbering: cycle 0 is the cycle in
// which start is presented; cycle k is the k-th cycle after that edge.
// Outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sound_tick_ctrl;

  localparam int N   = 16;
  localparam int K_W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           cfg_we = 1'b0;
  logic [N-1:0]   cfg_div = '0;
  logic [K_W-1:0] cfg_cnt = '0;
  logic           cfg_oneshot = 1'b0;
  logic           start = 1'b0;
  logic           stop = 1'b0;
  logic           tick;
  logic           busy;
  logic           done;
  logic           cfg_err;
`ifdef SOUND_TICK_IRQ_EN
  logic           irq_ack = 1'b0;
  logic           irq;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  sound_tick_ctrl #(.N(N), .K_W(K_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_div     (cfg_div),
    .cfg_cnt     (cfg_cnt),
    .cfg_oneshot (cfg_oneshot),
    .start       (start),
    .stop        (stop),
`ifdef SOUND_TICK_IRQ_EN
    .irq_ack     (irq_ack),
    .irq         (irq),
`endif
    .tick        (tick),
    .busy        (busy),
    .done        (done),
    .cfg_err     (cfg_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input int div, input int cnt, input logic os);
    cfg_we      = 1'b1;
    cfg_div     = N'(div);
    cfg_cnt     = K_W'(cnt);
    cfg_oneshot = os;
    next_cycle();
    cfg_we      = 1'b0;
  endtask

  // Present start in cycle 0, return positioned in cycle 1.
  task automatic start_run();
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    cyc   = 1;
  endtask

  // Check a running window from the current cycle through cycle last.
  task automatic run_until(input string tag, input int d, input int last);
    while (1'b1) begin
      check_val({tag, "_tick"}, tick, ((cyc % d) == 0));
      check_val({tag, "_busy"}, busy, 1'b1);
      check_val({tag, "_done"}, done, 1'b0);
      if (cyc >= last) break;
      next_cycle();
    end
  endtask

  task automatic do_stop(input string tag);
    stop = 1'b1;
    next_cycle();
    stop = 1'b0;
    check_val({tag, "_stop_busy"}, busy, 1'b0);
    check_val({tag, "_stop_done"}, done, 1'b0);
  endtask

  task automatic run_oneshot(input string tag, input int d, input int c_eff);
    start_run();
    run_until(tag, d, d * c_eff);
    next_cycle();
    check_val({tag, "_done_hi"}, done, 1'b1);
    check_val({tag, "_done_busy"}, busy, 1'b0);
    check_val({tag, "_done_tick"}, tick, 1'b0);
    next_cycle();
    check_val({tag, "_idle_done"}, done, 1'b0);
    check_val({tag, "_idle_busy"}, busy, 1'b0);
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      check_val({tag, "_tick"}, tick, 1'b0);
      check_val({tag, "_busy"}, busy, 1'b0);
      check_val({tag, "_done"}, done, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset asserted between edges: outputs must clear without a clock.
    #3 rst = 1'b1;
    #1;
    check_val("rst_tick", tick, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_cfg_err", cfg_err, 1'b0);
`ifdef SOUND_TICK_IRQ_EN
    check_val("rst_irq", irq, 1'b0);
`endif
    next_cycle();
    next_cycle();
    rst = 1'b0;
    quiet("post_rst", 3);

    // Periodic div=10: ticks 10/20/30, stop at 35, idle at 36.
    cfg_write(10, 0, 1'b0);
    start_run();
    run_until("per10", 10, 35);
    do_stop("per10");
    quiet("per10_after", 15);

    // Configuration write during RUN is rejected and flagged.
    cfg_write(10, 0, 1'b0);
    start_run();
    run_until("cfgrun_a", 10, 2);
    cfg_we  = 1'b1;
    cfg_div = N'(3);
    next_cycle();
    cfg_we  = 1'b0;
    check_val("cfgrun_err_hi", cfg_err, 1'b1);
    next_cycle();
    check_val("cfgrun_err_lo", cfg_err, 1'b0);
    run_until("cfgrun_b", 10, 20);
    do_stop("cfgrun");

    // One-shot div=4 cnt=3: ticks 4/8/12, done 13, idle 14.
    cfg_write(4, 3, 1'b1);
    run_oneshot("os4x3", 4, 3);

    // Divisor boundaries 0 and 1 both tick every RUN cycle.
    cfg_write(0, 0, 1'b0);
    start_run();
    run_until("div0", 1, 6);
    do_stop("div0");
    cfg_write(1, 0, 1'b0);
    start_run();
    run_until("div1", 1, 6);
    do_stop("div1");

    // cnt=0 one-shot completes after one tick.
    cfg_write(3, 0, 1'b1);
    run_oneshot("cnt0", 3, 1);

    // start+stop in IDLE stays idle.
    cfg_write(5, 0, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    next_cycle();
    start = 1'b0;
    stop  = 1'b0;
    check_val("ss_idle_busy", busy, 1'b0);
    quiet("ss_idle", 6);

    // start during RUN does not retrigger: ticks stay at 5, 10.
    start_run();
    run_until("noretrig_a", 5, 3);
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    run_until("noretrig_b", 5, 10);
    // Tick coincident with stop is still emitted.
    stop = 1'b1;
    #1;
    check_val("stop_coinc_tick", tick, 1'b1);
    next_cycle();
    stop = 1'b0;
    check_val("stop_coinc_busy", busy, 1'b0);
    quiet("stop_coinc", 6);

    // start+stop in RUN returns to IDLE.
    start_run();
    run_until("ss_run", 5, 3);
    start = 1'b1;
    stop  = 1'b1;
    next_cycle();
    start = 1'b0;
    stop  = 1'b0;
    check_val("ss_run_busy", busy, 1'b0);
    quiet("ss_run", 6);

    // cfg_we+start together in IDLE runs with the new divisor 2.
    cfg_we  = 1'b1;
    cfg_div = N'(2);
    cfg_cnt = '0;
    cfg_oneshot = 1'b0;
    start_run();
    cfg_we  = 1'b0;
    run_until("cfgstart", 2, 8);
    do_stop("cfgstart");

    // start in DONE: done still pulses and a new run begins directly.
    cfg_write(2, 1, 1'b1);
    start_run();
    run_until("sdone_a", 2, 2);
    next_cycle();
    check_val("sdone_done1", done, 1'b1);
    start_run();
    check_val("sdone_busy", busy, 1'b1);
    run_until("sdone_b", 2, 2);
    next_cycle();
    check_val("sdone_done2", done, 1'b1);
    next_cycle();
    check_val("sdone_idle_busy", busy, 1'b0);
    check_val("sdone_idle_done", done, 1'b0);

    // Asynchronous reset with the counter at 5 (cycle 6 of a div=10 run).
    cfg_write(10, 0, 1'b0);
    start_run();
    run_until("rstrun", 10, 6);
    #2 rst = 1'b1;
    #1;
    check_val("rstrun_busy", busy, 1'b0);
    check_val("rstrun_done", done, 1'b0);
    check_val("rstrun_tick", tick, 1'b0);
    next_cycle();
    rst = 1'b0;
    quiet("rstrun_after", 25);
    // Reset cleared the divisor and mode: a bare start runs periodic, D=1.
    start_run();
    run_until("rst_cfg", 1, 4);
    do_stop("rst_cfg");

`ifdef SOUND_TICK_IRQ_EN
    irq_ack = 1'b1;
    next_cycle();
    irq_ack = 1'b0;
    check_val("irq_clear0", irq, 1'b0);
    cfg_write(2, 1, 1'b1);
    start_run();
    run_until("irq_os", 2, 2);
    next_cycle();
    check_val("irq_done", done, 1'b1);
    check_val("irq_pre", irq, 1'b0);
    next_cycle();
    check_val("irq_set", irq, 1'b1);
    next_cycle();
    check_val("irq_hold", irq, 1'b1);
    irq_ack = 1'b1;
    next_cycle();
    irq_ack = 1'b0;
    check_val("irq_ack_clr", irq, 1'b0);
    // cfg_err coinciding with irq_ack: set wins.
    cfg_write(10, 0, 1'b0);
    start_run();
    cfg_we = 1'b1;
    next_cycle();
    cfg_we = 1'b0;
    check_val("irq_err", cfg_err, 1'b1);
    irq_ack = 1'b1;
    next_cycle();
    irq_ack = 1'b0;
    check_val("irq_set_wins", irq, 1'b1);
    do_stop("irq");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sound_tick_ctrl

// File: doc/sound_tick_ctrl.md
SOUND_TICK_CTRL -- requirements
Module: sound_tick_ctrl

Interface
REQ-001 The block SHALL have parameter N, default 16, meaning the width of the divisor and of the tick counter.
REQ-002 The block SHALL have parameter K_W, default 8, meaning the width of the one-shot tick count.
REQ-003 The block SHALL have port clk, input, 1 bit, the system clock; all state SHALL change on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, the reset: asynchronous, active-high.
REQ-005 The block SHALL have port cfg_we, input, 1 bit, the configuration write strobe.
REQ-006 The block SHALL have port cfg_div, input, N bits, the tick period in clk cycles.
REQ-007 The block SHALL have port cfg_cnt, input, K_W bits, the number of ticks per one-shot run.
REQ-008 The block SHALL have port cfg_oneshot, input, 1 bit: 1 selects one-shot mode, 0 selects periodic mode.
REQ-009 The block SHALL have port start, input, 1 bit, the run request.
REQ-010 The block SHALL have port stop, input, 1 bit, the abort request.
REQ-011 The block SHALL have port tick, output, 1 bit, a single-cycle period pulse.
REQ-012 The block SHALL have port busy, output, 1 bit, which is high while the state is RUN.
REQ-013 The block SHALL have port done, output, 1 bit, a single-cycle pulse at one-shot completion.
REQ-014 The block SHALL have port cfg_err, output, 1 bit, a single-cycle pulse when a configuration write is rejected.

Function
REQ-015 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, cfg_we SHALL latch cfg_div, cfg_cnt and cfg_oneshot into internal registers (div_r, cnt_r, mode_r).
REQ-017 In RUN, cfg_we SHALL be ignored, the registers SHALL be unchanged, and cfg_err SHALL pulse in the following cycle.
REQ-018 The effective period SHALL be D = max(div_r, 1); the effective count SHALL be C = max(cnt_r, 1).
REQ-019 start sampled in IDLE or DONE SHALL move the state to RUN, clear the tick counter to 0 and clear the tick tally to 0.
REQ-020 start sampled in RUN SHALL be ignored, with no retrigger.
REQ-021 In RUN, the tick counter SHALL increment each cycle, wrap to 0 when it equals D-1, and tick SHALL be high exactly in cycles where the counter equals D-1.
REQ-022 With start sampled at the end of cycle c, the first tick SHALL occur in cycle c+D and subsequent ticks every D cycles; for D=1, tick SHALL be high every RUN cycle.
REQ-023 Tick counter arithmetic SHALL be N-bit unsigned, and the compare SHALL use D-1 computed at N bits.
REQ-024 In one-shot mode, the tally SHALL count ticks (K_W bits); on the C-th tick the state SHALL go to DONE, and done SHALL be high for the single cycle spent in DONE, after which the state SHALL go to IDLE.
REQ-025 In periodic mode, RUN SHALL persist until stop.
REQ-026 stop sampled in RUN SHALL return the state to IDLE next cycle without asserting done; a tick coincident with stop SHALL still be emitted.
REQ-027 stop and start sampled together SHALL act as stop; stop in IDLE or DONE SHALL be ignored.
REQ-028 cfg_we and start sampled together in IDLE SHALL latch the new configuration and start with the new values.
REQ-029 A start in DONE SHALL start a new run directly, and done SHALL still be pulsed in that cycle.

Reset
REQ-030 When rst is asserted, the block SHALL set state=IDLE, counter=0, tally=0, div_r=0, cnt_r=0, mode_r=0, and tick=busy=done=cfg_err=0 immediately, independent of clk.
REQ-031 rst asserted mid-run SHALL abort the run with no done pulse, and no tick SHALL occur before a new start.

Configuration
REQ-032 With SOUND_TICK_IRQ_EN defined, the block SHALL add input irq_ack (1 bit) and output irq (1 bit); irq SHALL be set on done or cfg_err, cleared by irq_ack, and set wins over a simultaneous irq_ack; irq SHALL be 0 on reset.
REQ-033 Without SOUND_TICK_IRQ_EN, the irq and irq_ack ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Package sound_tick_pkg SHALL hold the state encoding (IDLE, RUN, DONE) and the default widths N and K_W.
REQ-035 Sub-module tick_div_counter SHALL implement the N-bit programmable modulo counter: inputs clr, en and period; output wrap; instantiated once.
REQ-036 The FSM, configuration registers and tally SHALL reside in sound_tick_ctrl.

Verification
REQ-037 Periodic: write div=10 with oneshot=0, start at cycle 0, then ticks SHALL occur at cycles 10, 20 and 30, and stop at cycle 35 SHALL give busy=0 at cycle 36 with no further ticks.
REQ-038 One-shot: write div=4, cnt=3, oneshot=1, start at cycle 0, then ticks SHALL occur at cycles 4, 8 and 12, done SHALL be high at cycle 13 only, and the state SHALL be IDLE at cycle 14.
REQ-039 Boundaries: div=0 and div=1 SHALL both tick every RUN cycle; cnt=0 in one-shot mode SHALL complete after 1 tick.
REQ-040 Config during RUN: cfg_we with div=3 while running div=10 SHALL pulse cfg_err one cycle later and leave the period at 10.
REQ-041 Collisions: start+stop together in IDLE SHALL leave busy=0; start+stop together in RUN SHALL go to IDLE; cfg_we+start together SHALL run with the new divisor.
REQ-042 Reset mid-run: rst asserted asynchronously at counter=5 SHALL drop busy immediately with no done; with SOUND_TICK_IRQ_EN, irq SHALL set on done, hold, and clear one cycle after irq_ack.
